// File: rtl/clk_en_ctrl.sv
// Clock-enable / divider controller: 1-cycle tick plus registered divided clock, with
// run/stop control and a valid/ready ratio update that applies only at a period boundary.
module clk_en_ctrl #(
  parameter int unsigned CNT_W   = 22,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             tick,
  output logic             clk_out,
  output logic             active,
  output logic [CNT_W-1:0] cur_div
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV   = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;

  logic             accept;
  logic             boundary;
  logic [CNT_W-1:0] cfg_div_clamped;
  logic [CNT_W-1:0] cnt_next_wrap;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_STOP;
      cnt_q     <= '0;
      cur_div_q <= DEF_DIV_C;
      pend_q    <= DEF_DIV_C;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cur_div_d       = cur_div_q;
    pend_d          = pend_q;
    done_d          = 1'b0;
    accept          = cfg_valid && (state_q != ST_SWITCH);
    boundary        = (state_q != ST_STOP) && (cnt_q == cur_div_q - ONE);
    cfg_div_clamped = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
    cnt_next_wrap   = boundary ? '0 : cnt_q + ONE;
    case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        if (accept) begin
          cur_div_d = cfg_div_clamped;
          done_d    = 1'b1;
        end
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_next_wrap;
        // An accept wins over a stop request at the same boundary; the stop is
        // re-evaluated at the boundary that applies the new ratio.
        if (accept) begin
          pend_d  = cfg_div_clamped;
          state_d = ST_SWITCH;
        end else if (boundary && !run) begin
          state_d = ST_STOP;
        end
      end
      ST_SWITCH: begin
        cnt_d = cnt_next_wrap;
        if (boundary) begin
          cur_div_d = pend_q;
          done_d    = 1'b1;
          state_d   = run ? ST_RUN : ST_STOP;
        end
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase
  end

  // tick/clk_out are registered from next-state values so they line up with cnt/state.
  always_comb begin
    tick_d    = (state_d != ST_STOP) && (cnt_d == cur_div_d - ONE);
    clk_out_d = (state_d != ST_STOP) && (cnt_d >= (cur_div_d >> 1));
    cfg_ready = (state_q != ST_SWITCH);
    active    = (state_q != ST_STOP);
  end

  assign cfg_done = done_q;
  assign tick     = tick_q;
  assign clk_out  = clk_out_q;
  assign cur_div  = cur_div_q;

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Randomized bench for clk_en_ctrl against a period-position reference model.
module tb_clk_en_ctrl;

  localparam int unsigned CNT_W = 22;

  logic             clk = 1'b0;
  logic             clr;
  logic             run;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_done;
  logic             tick;
  logic             clk_out;
  logic             active;
  logic [CNT_W-1:0] cur_div;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  clk_en_ctrl #(.CNT_W(CNT_W), .DEF_DIV(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .tick     (tick),
    .clk_out  (clk_out),
    .active   (active),
    .cur_div  (cur_div)
  );

  always #5 clk = ~clk;

  // Reference model: "is the generator running", position within the current period,
  // ratio in effect and an optional pending ratio waiting for the next period end.
  bit running;
  int pos;
  int div;
  bit pending;
  int pend_div;
  bit done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int clamp_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    running  = 0;
    pos      = 0;
    div      = 4;
    pending  = 0;
    pend_div = 4;
    done     = 0;
  endtask

  task automatic model_step(input bit r, input bit v, input int d);
    bit acc;
    bit period_end;
    acc  = v && !pending;
    done = 0;
    if (!running) begin
      if (acc) begin
        div  = clamp_div(d);
        done = 1;
      end
      if (r) begin
        running = 1;
        pos     = 0;
      end
    end else begin
      period_end = (pos == div - 1);
      pos = period_end ? 0 : pos + 1;
      if (period_end && pending) begin
        div     = pend_div;
        pending = 0;
        done    = 1;
        running = r;
      end else if (period_end && !r && !acc) begin
        running = 0;
      end
      if (acc) begin
        pending  = 1;
        pend_div = clamp_div(d);
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("tick",      32'(tick),      32'(running && pos == div - 1));
    check_eq("clk_out",   32'(clk_out),   32'(running && pos >= div / 2));
    check_eq("active",    32'(active),    32'(running));
    check_eq("cfg_ready", 32'(cfg_ready), 32'(!pending));
    check_eq("cfg_done",  32'(cfg_done),  32'(done));
    check_eq("cur_div",   32'(cur_div),   32'(div));
  endtask

  task automatic check_reset_values();
    check_eq("rst_tick",      32'(tick),      32'd0);
    check_eq("rst_clk_out",   32'(clk_out),   32'd0);
    check_eq("rst_active",    32'(active),    32'd0);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_cfg_done",  32'(cfg_done),  32'd0);
    check_eq("rst_cur_div",   32'(cur_div),   32'd4);
  endtask

  initial begin
    clr       = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    model_reset();
    #12;
    check_reset_values();
    @(negedge clk);
    clr = 1'b0;

    for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_outputs();
      if (cyc < 30) begin
        run       = 1'b1;
        cfg_valid = 1'b0;
      end else begin
        if ($urandom_range(0, 24) == 0) run = ~run;
        cfg_valid = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 5))
          0:       cfg_div = CNT_W'($urandom_range(0, 1));
          1:       cfg_div = CNT_W'($urandom_range(2, 3));
          default: cfg_div = CNT_W'($urandom_range(2, 12));
        endcase
      end
      model_step(run, cfg_valid, int'(cfg_div));

      if (cyc > 30 && $urandom_range(0, 299) == 0) begin
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        clr       = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        model_step(1'b0, 1'b0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
